// File: rtl/mem_pkg.sv
// Shared encodings for the RAM port: data lengths, RW direction and arbiter states.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [1:0] DL_BYTE = 2'b00;
    localparam logic [1:0] DL_HALF = 2'b01;
    localparam logic [1:0] DL_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Two requesters on one side, the single RAM handshake port on the other.
interface mem_port_arbiter_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [1:0]        req;
    logic [1:0]        rw;
    logic [1:0]        dl0;
    logic [1:0]        dl1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mov;
    logic              mem_rw;
    logic [1:0]        mem_dl;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              moc;

    modport master (
        input  req, rw, dl0, dl1, addr0, addr1, wdata0, wdata1, moc, mem_rdata,
        output done, err, rdata, busy, mov, mem_rw, mem_dl, mem_addr, mem_wdata
    );

    modport slave (
        output req, rw, dl0, dl1, addr0, addr1, wdata0, wdata1, moc, mem_rdata,
        input  done, err, rdata, busy, mov, mem_rw, mem_dl, mem_addr, mem_wdata
    );

endinterface

// File: rtl/moc_sync.sv
// Two-flop synchroniser for the asynchronous RAM MOC acknowledge.
module moc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two-stage capture of the async input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto the RAM MOV/MOC port with a no-answer watchdog.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 15,
    parameter bit          RR_EN   = 1'b1
) (
    input  logic               main_clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_n;
    logic              owner_q, owner_n;
    logic              last_grant_q, last_grant_n;
    logic [WD_W-1:0]   wdog_q, wdog_n;
    logic              mov_q, mov_n;
    logic [1:0]        done_q, done_n;
    logic              err_q, err_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              busy_q, busy_n;
    logic              mem_rw_q, mem_rw_n;
    logic [1:0]        mem_dl_q, mem_dl_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
    logic              moc_s;
    logic              winner_c;

    moc_sync u_moc_sync (
        .clk   (main_clk),
        .rst_n (reset),
        .d     (bus.moc),
        .q     (moc_s)
    );

    // Winner: on contention the requester not served last (or requester 0 in fixed mode)
    always_comb begin
        winner_c = bus.req[1];
        if (bus.req == 2'b11) begin
            winner_c = RR_EN ? ~last_grant_q : 1'b0;
        end
    end

    // Next state and registered-output values
    always_comb begin
        state_n      = state_q;
        owner_n      = owner_q;
        last_grant_n = last_grant_q;
        wdog_n       = wdog_q;
        mov_n        = mov_q;
        done_n       = 2'b00;
        err_n        = 1'b0;
        rdata_n      = rdata_q;
        mem_rw_n     = mem_rw_q;
        mem_dl_n     = mem_dl_q;
        mem_addr_n   = mem_addr_q;
        mem_wdata_n  = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    owner_n     = winner_c;
                    mem_rw_n    = winner_c ? bus.rw[1] : bus.rw[0];
                    mem_dl_n    = winner_c ? bus.dl1 : bus.dl0;
                    mem_addr_n  = winner_c ? bus.addr1 : bus.addr0;
                    mem_wdata_n = winner_c ? bus.wdata1 : bus.wdata0;
                    mov_n       = 1'b1;
                    wdog_n      = '0;
                    state_n     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (moc_s) begin
                    if (mem_rw_q == RW_READ) begin
                        rdata_n = bus.mem_rdata;
                    end
                    done_n[owner_q] = 1'b1;
                    last_grant_n    = owner_q;
                    mov_n           = 1'b0;
                    state_n         = ST_RELEASE;
                end else if (wdog_q == WD_LAST) begin
                    done_n[owner_q] = 1'b1;
                    err_n           = 1'b1;
                    rdata_n         = '0;
                    mov_n           = 1'b0;
                    state_n         = ST_RELEASE;
                end else begin
                    wdog_n = wdog_q + WD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!moc_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                mov_n   = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers; reset abandons any handshake in flight
    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            mov_q        <= 1'b0;
            done_q       <= 2'b00;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            mem_rw_q     <= RW_WRITE;
            mem_dl_q     <= DL_BYTE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_n;
            owner_q      <= owner_n;
            last_grant_q <= last_grant_n;
            wdog_q       <= wdog_n;
            mov_q        <= mov_n;
            done_q       <= done_n;
            err_q        <= err_n;
            rdata_q      <= rdata_n;
            busy_q       <= busy_n;
            mem_rw_q     <= mem_rw_n;
            mem_dl_q     <= mem_dl_n;
            mem_addr_q   <= mem_addr_n;
            mem_wdata_q  <= mem_wdata_n;
        end
    end

    assign bus.mov       = mov_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_dl    = mem_dl_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a behavioural RAM responder.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 15;
    localparam bit          RR_EN   = 1'b1;

    typedef struct {
        logic              owner;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic main_clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .RR_EN   (RR_EN)
    ) dut (
        .main_clk (main_clk),
        .reset    (reset),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    exp_t sb[$];

    // RAM responder knobs, written only by the stimulus process
    int noans_pct = 0;
    int lat_min   = 0;
    int lat_max   = 3;
    int hold_min  = 0;
    int hold_max  = 2;

    // Requester inputs as the DUT saw them at the last rising edge
    logic [1:0]        req_seen;
    logic [1:0]        rw_seen;
    logic [1:0]        dl_seen    [2];
    logic [ADDR_W-1:0] addr_seen  [2];
    logic [DATA_W-1:0] wdata_seen [2];

    initial begin
        main_clk = 1'b0;
        forever #5 main_clk = ~main_clk;
    end

    always @(posedge main_clk) begin
        req_seen      <= bus.req;
        rw_seen       <= bus.rw;
        dl_seen[0]    <= bus.dl0;
        dl_seen[1]    <= bus.dl1;
        addr_seen[0]  <= bus.addr0;
        addr_seen[1]  <= bus.addr1;
        wdata_seen[0] <= bus.wdata0;
        wdata_seen[1] <= bus.wdata1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Arbitration rule: a lone requester wins; on contention the one not served last
    function automatic logic pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) return RR_EN ? !last : 1'b0;
        return (r == 2'b10);
    endfunction

    function automatic logic [DATA_W-1:0] ram_data(input logic [ADDR_W-1:0] a);
        if (a == 9'h004) return 32'hE3A01005;
        return DATA_W'($urandom());
    endfunction

    function automatic bit fields_bad(input logic rw, input logic [1:0] dl,
                                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        return (bus.mem_rw !== rw) || (bus.mem_dl !== dl) ||
               (bus.mem_addr !== a) || (bus.mem_wdata !== w);
    endfunction

    // RAM responder: predicts owner and response, pushes expectations, drives MOC
    initial begin : ram
        exp_t              e;
        logic              own;
        logic              e_rw;
        logic [1:0]        e_dl;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        logic [DATA_W-1:0] d;
        logic              m_last;
        logic [DATA_W-1:0] m_rdata;
        bit                noans, fbad, aborted;
        int                cnt, lat, hold;
        bus.moc       = 1'b0;
        bus.mem_rdata = '0;
        m_last        = 1'b1;
        m_rdata       = '0;
        forever begin
            @(negedge main_clk);
            if (!reset) begin
                m_last  = 1'b1;
                m_rdata = '0;
                bus.moc = 1'b0;
            end else if (bus.mov) begin
                chk("grant_had_request", 64'(req_seen != 2'b00), 64'd1);
                own     = pick(req_seen, m_last);
                e_rw    = rw_seen[own];
                e_dl    = dl_seen[own];
                e_addr  = addr_seen[own];
                e_wd    = wdata_seen[own];
                fbad    = 1'b0;
                aborted = 1'b0;
                noans   = ($urandom_range(99) < noans_pct);
                if (noans) begin
                    e.owner = own; e.err = 1'b1; e.rdata = '0;
                    sb.push_back(e);
                    m_rdata = '0;
                    cnt = 0;
                    while (bus.mov && reset && cnt < 40) begin
                        fbad |= fields_bad(e_rw, e_dl, e_addr, e_wd);
                        cnt++;
                        @(negedge main_clk);
                    end
                    if (reset) chk("timeout_mov_cycles", 64'(cnt), 64'(TIMEOUT));
                    else aborted = 1'b1;
                end else begin
                    lat = $urandom_range(lat_max, lat_min);
                    for (int k = 0; k < lat && !aborted; k++) begin
                        fbad |= fields_bad(e_rw, e_dl, e_addr, e_wd);
                        @(negedge main_clk);
                        if (!reset) aborted = 1'b1;
                    end
                    if (!aborted) begin
                        d             = ram_data(e_addr);
                        bus.mem_rdata = d;
                        bus.moc       = 1'b1;
                        e.owner = own; e.err = 1'b0; e.rdata = (e_rw == RW_READ) ? d : m_rdata;
                        sb.push_back(e);
                        m_rdata = e.rdata;
                        m_last  = own;
                        cnt = 0;
                        while (bus.mov && reset && cnt < 40) begin
                            fbad |= fields_bad(e_rw, e_dl, e_addr, e_wd);
                            cnt++;
                            @(negedge main_clk);
                        end
                        if (!reset) aborted = 1'b1;
                        else chk("mov_drop_after_moc", 64'(cnt < 40), 64'd1);
                        hold = $urandom_range(hold_max, hold_min);
                        for (int k = 0; k < hold && !aborted; k++) @(negedge main_clk);
                    end
                end
                bus.moc = 1'b0;
                if (aborted) begin
                    m_last  = 1'b1;
                    m_rdata = '0;
                end else begin
                    chk("mem_fields_stable", 64'(fbad), 64'd0);
                end
            end
        end
    end

    // Monitor: every done pulse is matched against the oldest expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge main_clk);
            if (reset) begin
                if (bus.done == 2'b11) chk("done_onehot", 64'(bus.done), 64'd1);
                if (bus.done != 2'b00) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'(bus.done), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_owner", 64'(bus.done), e.owner ? 64'd2 : 64'd1);
                        chk("done_err", 64'(bus.err), 64'(e.err));
                        chk("done_rdata", 64'(bus.rdata), 64'(e.rdata));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge main_clk);
        #2;
    endtask

    task automatic set_fields(input int i, input logic rw, input logic [1:0] dl,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        bus.rw[i] = rw;
        if (i == 0) begin bus.dl0 = dl; bus.addr0 = a; bus.wdata0 = w; end
        else        begin bus.dl1 = dl; bus.addr1 = a; bus.wdata1 = w; end
    endtask

    task automatic wait_done(input int i, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            if (bus.done[i]) ok = 1'b1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            if (!bus.busy) ok = 1'b1;
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic run_one(input int i, input logic rw, input logic [1:0] dl,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        set_fields(i, rw, dl, a, w);
        bus.req[i] = 1'b1;
        wait_done(i, "done_within_budget");
        bus.req[i] = 1'b0;
    endtask

    // Directed scenarios followed by a randomised contention run
    initial begin : stim
        int          order [4];
        int          ndone, cyc;
        int          gap   [2];
        bit          ok;
        logic [1:0]  dlr;
        reset = 1'b0;
        bus.req = 2'b00;
        set_fields(0, RW_WRITE, DL_BYTE, '0, '0);
        set_fields(1, RW_WRITE, DL_BYTE, '0, '0);
        repeat (3) tick();
        chk("rst_mov", 64'(bus.mov), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Single word read
        run_one(0, RW_READ, DL_WORD, 9'h004, 32'h0);
        chk("t1_rdata", 64'(bus.rdata), 64'hE3A01005);
        chk("t1_err", 64'(bus.err), 64'd0);
        wait_idle("t1_idle");

        // Byte write; owner inputs scrambled once granted
        lat_min = 3; lat_max = 5;
        set_fields(1, RW_WRITE, DL_BYTE, 9'h1FF, 32'h000000AB);
        bus.req[1] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin tick(); ok = bus.mov; end
        chk("t3_granted", 64'(ok), 64'd1);
        set_fields(1, RW_READ, DL_WORD, 9'h000, 32'hFFFFFFFF);
        tick();
        chk("t3_mem_dl", 64'(bus.mem_dl), 64'(DL_BYTE));
        chk("t3_mem_addr", 64'(bus.mem_addr), 64'h1FF);
        chk("t3_mem_wdata", 64'(bus.mem_wdata), 64'hAB);
        wait_done(1, "t3_done");
        bus.req[1] = 1'b0;
        chk("t3_rdata_kept", 64'(bus.rdata), 64'hE3A01005);
        wait_idle("t3_idle");

        // Watchdog abort, then a normal transfer
        lat_min = 0; lat_max = 3; noans_pct = 100;
        run_one(0, RW_READ, DL_WORD, 9'h010, 32'h0);
        chk("t4_err", 64'(bus.err), 64'd1);
        chk("t4_rdata", 64'(bus.rdata), 64'd0);
        noans_pct = 0;
        wait_idle("t4_idle");
        run_one(1, RW_READ, DL_HALF, 9'h020, 32'h0);
        chk("t4_next_err", 64'(bus.err), 64'd0);
        wait_idle("t4_next_idle");

        // Stuck MOC holds off the second grant
        hold_min = 12; hold_max = 12;
        set_fields(0, RW_READ, DL_WORD, 9'h030, 32'h0);
        set_fields(1, RW_WRITE, DL_WORD, 9'h031, 32'h12345678);
        bus.req = 2'b11;
        wait_done(0, "t6_first_done");
        bus.req[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t6_no_grant", 64'({bus.mov, bus.busy}), 64'd1);
        end
        hold_min = 0; hold_max = 2;
        wait_done(1, "t6_second_done");
        bus.req[1] = 1'b0;
        wait_idle("t6_idle");

        // Reset three cycles into ACCESS
        lat_min = 10; lat_max = 10;
        set_fields(1, RW_READ, DL_WORD, 9'h040, 32'h0);
        bus.req[1] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin tick(); ok = bus.mov; end
        chk("t5_granted", 64'(ok), 64'd1);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("t5_mov_async", 64'(bus.mov), 64'd0);
        chk("t5_no_done", 64'(bus.done), 64'd0);
        bus.req = 2'b00;
        repeat (2) tick();
        reset = 1'b1;
        lat_min = 0; lat_max = 3;
        tick();

        // Held contention alternates 0,1,0,1
        set_fields(0, RW_READ, DL_WORD, 9'h050, 32'h0);
        set_fields(1, RW_READ, DL_WORD, 9'h051, 32'h0);
        bus.req = 2'b11;
        ndone = 0;
        for (int c = 0; c < 400 && ndone < 4; c++) begin
            tick();
            if (bus.done != 2'b00) begin
                order[ndone] = bus.done[1] ? 1 : 0;
                ndone++;
            end
        end
        bus.req = 2'b00;
        chk("t2_count", 64'(ndone), 64'd4);
        for (int k = 0; k < ndone; k++) chk("t2_order", 64'(order[k]), 64'(k % 2));
        wait_idle("t2_idle");

        // Randomised traffic
        noans_pct = 8; lat_min = 0; lat_max = 5; hold_min = 0; hold_max = 3;
        gap[0] = 0; gap[1] = 1;
        ndone = 0; cyc = 0;
        while (ndone < 150 && cyc < 20000) begin
            tick();
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (bus.req[i] && bus.done[i]) begin
                    bus.req[i] = 1'b0;
                    gap[i] = $urandom_range(3);
                    ndone++;
                end else if (!bus.req[i]) begin
                    if (gap[i] == 0) begin
                        dlr = 2'($urandom_range(2));
                        set_fields(i, 1'($urandom_range(1)), dlr, ADDR_W'($urandom()), DATA_W'($urandom()));
                        bus.req[i] = 1'b1;
                    end else begin
                        gap[i]--;
                    end
                end
            end
        end
        chk("rand_completions", 64'(ndone >= 150), 64'd1);
        bus.req = 2'b00;
        wait_idle("rand_idle");
        repeat (5) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
